// File: rtl/conf_bus_master.sv
// Frames a host byte stream (address bytes, then data bytes, MSB first) into write
// commands on the configuration simple interface, with ack and partial-frame timeouts.
module conf_bus_master #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int ACK_TIMEOUT   = 8,
  parameter int FRAME_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rdy,
  output logic                  rx_ack,
  output logic [ADDR_WIDTH-1:0] si_addr,
  output logic [DATA_WIDTH-1:0] si_data,
  output logic                  si_rdy,
  input  logic                  si_ack,
  output logic                  busy,
  output logic                  wr_done,
  output logic                  err_nack,
  output logic                  err_frame,
  output logic [7:0]            err_count
);

  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int BCW        = $clog2(MAX_BYTES + 1);
  localparam int WCW        = $clog2(ACK_TIMEOUT + 1);
  localparam int ICW        = (FRAME_TIMEOUT > 0) ? $clog2(FRAME_TIMEOUT + 1) : 1;

  localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTES - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTES - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(ACK_TIMEOUT - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'((FRAME_TIMEOUT > 0) ? FRAME_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {RX_ADDR, RX_DATA, WRITE} state_t;

  state_t                  state_reg, state_next;
  logic [BCW-1:0]          byte_cnt_reg, byte_cnt_next;
  logic [WCW-1:0]          wait_cnt_reg, wait_cnt_next;
  logic [ICW-1:0]          idle_cnt_reg, idle_cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic                    wr_done_reg, wr_done_next;
  logic                    err_nack_reg, err_nack_next;
  logic                    err_frame_reg, err_frame_next;
  logic [7:0]              err_count_reg, err_count_next;
  logic                    accept;
  logic                    frame_open;

  assign rx_ack     = rx_rdy & ~rst & (state_reg != WRITE);
  assign accept     = rx_rdy & rx_ack;
  assign frame_open = (state_reg == RX_DATA) | (byte_cnt_reg != '0);

  always_comb begin
    state_next     = state_reg;
    byte_cnt_next  = byte_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    idle_cnt_next  = idle_cnt_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    wr_done_next   = 1'b0;
    err_nack_next  = 1'b0;
    err_frame_next = 1'b0;
    err_count_next = err_count_reg;

    case (state_reg)
      RX_ADDR, RX_DATA: begin
        if (accept) begin
          idle_cnt_next = '0;
          if (state_reg == RX_ADDR) begin
            addr_next = ADDR_WIDTH'({addr_reg, rx_data});
            if (byte_cnt_reg == ADDR_LAST) begin
              state_next    = RX_DATA;
              byte_cnt_next = '0;
            end else begin
              byte_cnt_next = byte_cnt_reg + 1'b1;
            end
          end else begin
            data_next = DATA_WIDTH'({data_reg, rx_data});
            if (byte_cnt_reg == DATA_LAST) begin
              state_next    = WRITE;
              byte_cnt_next = '0;
              wait_cnt_next = '0;
            end else begin
              byte_cnt_next = byte_cnt_reg + 1'b1;
            end
          end
        end else if (frame_open && (FRAME_TIMEOUT > 0)) begin
          // An accepted byte takes priority over an expiring idle count.
          if (idle_cnt_reg == IDLE_LAST) begin
            state_next     = RX_ADDR;
            byte_cnt_next  = '0;
            idle_cnt_next  = '0;
            err_frame_next = 1'b1;
          end else begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
          end
        end
      end
      WRITE: begin
        if (si_ack) begin
          state_next   = RX_ADDR;
          wr_done_next = 1'b1;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          state_next    = RX_ADDR;
          err_nack_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      default: state_next = RX_ADDR;
    endcase

    if ((err_nack_next | err_frame_next) && (err_count_reg != 8'hFF))
      err_count_next = err_count_reg + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RX_ADDR;
      byte_cnt_reg  <= '0;
      wait_cnt_reg  <= '0;
      idle_cnt_reg  <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      wr_done_reg   <= 1'b0;
      err_nack_reg  <= 1'b0;
      err_frame_reg <= 1'b0;
      err_count_reg <= 8'd0;
    end else begin
      state_reg     <= state_next;
      byte_cnt_reg  <= byte_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      idle_cnt_reg  <= idle_cnt_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      wr_done_reg   <= wr_done_next;
      err_nack_reg  <= err_nack_next;
      err_frame_reg <= err_frame_next;
      err_count_reg <= err_count_next;
    end
  end

  assign si_rdy    = (state_reg == WRITE);
  assign si_addr   = addr_reg;
  assign si_data   = data_reg;
  assign busy      = (state_reg != RX_ADDR) | (byte_cnt_reg != '0);
  assign wr_done   = wr_done_reg;
  assign err_nack  = err_nack_reg;
  assign err_frame = err_frame_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_conf_bus_master.sv
// Directed and randomized checks of conf_bus_master against a frame-level model
// and a small bank of registers that ack any address below 0x0040.
module tb_conf_bus_master;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_ack;
  logic [15:0] si_addr;
  logic [15:0] si_data;
  logic        si_rdy;
  logic        si_ack;
  logic        busy;
  logic        wr_done;
  logic        err_nack;
  logic        err_frame;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;

  conf_bus_master #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .ACK_TIMEOUT(8), .FRAME_TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ack(rx_ack),
    .si_addr(si_addr), .si_data(si_data), .si_rdy(si_rdy), .si_ack(si_ack),
    .busy(busy), .wr_done(wr_done), .err_nack(err_nack), .err_frame(err_frame),
    .err_count(err_count)
  );

  function automatic logic has_reg(input logic [15:0] a);
    return a < 16'h0040;
  endfunction

  assign si_ack = si_rdy && has_reg(si_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sole writer of everything below; the main sequence only reads it.
  logic [15:0] bank [0:63];
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int n_done = 0, n_nack = 0, n_frame = 0, n_overlap = 0, n_acc = 0;
  int si_run = 0, last_run = 0;

  always @(negedge clk) begin
    if (si_rdy && si_ack) begin
      wr_addr_q.push_back(si_addr);
      wr_data_q.push_back(si_data);
      bank[si_addr[5:0]] = si_data;
    end
    if (wr_done)          n_done++;
    if (err_nack)         n_nack++;
    if (err_frame)        n_frame++;
    if (si_rdy && rx_ack) n_overlap++;
    if (rx_rdy && rx_ack) n_acc++;
    if (si_rdy) si_run++;
    else if (si_run != 0) begin
      last_run = si_run;
      si_run   = 0;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done    = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int k = 0; k < 64 && !done; k++) begin
      #1;
      if (rx_ack) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] d, input int gap_max);
    logic [7:0] bytes [4];
    bytes[0] = a[15:8]; bytes[1] = a[7:0]; bytes[2] = d[15:8]; bytes[3] = d[7:0];
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      if (gap_max > 0) begin
        rx_rdy = 1'b0;
        repeat ($urandom_range(0, gap_max)) cycle();
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 64 && busy; k++) cycle();
    check("wait_idle", {31'd0, busy}, 32'd0);
    cycle();
  endtask

  int          exp_err;
  int          w0, d0, nk0, fr0, ov0, ac0;
  logic [15:0] a, d;
  logic [15:0] ea [16];
  logic [15:0] ed [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
    repeat (3) cycle();
    rx_rdy = 1'b1;
    #1;
    check("rst_rx_ack", {31'd0, rx_ack}, 32'd0);
    check("rst_si_rdy", {31'd0, si_rdy}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_si_addr", {16'd0, si_addr}, 32'd0);
    check("rst_si_data", {16'd0, si_data}, 32'd0);
    check("rst_pulses", {29'd0, wr_done, err_nack, err_frame}, 32'd0);
    rx_rdy = 1'b0;
    rst = 1'b0;
    exp_err = 0;
    cycle();

    // Basic write with rx_rdy held: si_rdy one cycle after the last byte, one-cycle bubble.
    send_byte(8'h00); send_byte(8'h0A); send_byte(8'h12); send_byte(8'h34);
    check("t1_si_rdy", {31'd0, si_rdy}, 32'd1);
    check("t1_si_addr", {16'd0, si_addr}, 32'h000A);
    check("t1_si_data", {16'd0, si_data}, 32'h1234);
    check("t1_rx_ack_write", {31'd0, rx_ack}, 32'd0);
    cycle();
    check("t1_wr_done", {31'd0, wr_done}, 32'd1);
    check("t1_si_rdy_low", {31'd0, si_rdy}, 32'd0);
    check("t1_rx_ack_bubble", {31'd0, rx_ack}, 32'd1);
    rx_rdy = 1'b0;
    check("t1_bank", {16'd0, bank[6'h0A]}, 32'h1234);
    cycle();

    // Write to an absent register: ack timeout after exactly 8 si_rdy cycles.
    nk0 = n_nack;
    send_frame(16'h00FF, 16'hBEEF, 0);
    rx_rdy = 1'b0;
    wait_idle();
    exp_err++;
    check("t2_si_rdy_len", last_run, 32'd8);
    check("t2_nack_pulses", n_nack - nk0, 32'd1);
    check("t2_err_count", {24'd0, err_count}, exp_err);
    send_frame(16'h000A, 16'hA5C3, 0);
    rx_rdy = 1'b0;
    wait_idle();
    check("t2_bank", {16'd0, bank[6'h0A]}, 32'hA5C3);

    // Partial frame stalled: 255 idle cycles tolerated, then discarded.
    fr0 = n_frame;
    send_byte(8'h00); send_byte(8'h0A); send_byte(8'h12);
    rx_rdy = 1'b0;
    repeat (254) cycle();
    check("t3_busy_before", {31'd0, busy}, 32'd1);
    check("t3_no_frame_err_yet", {31'd0, err_frame}, 32'd0);
    cycle();
    check("t3_err_frame", {31'd0, err_frame}, 32'd1);
    check("t3_busy_after", {31'd0, busy}, 32'd0);
    exp_err++;
    check("t3_err_count", {24'd0, err_count}, exp_err);
    send_frame(16'h000B, 16'h5678, 0);
    rx_rdy = 1'b0;
    wait_idle();
    check("t3_frame_pulses", n_frame - fr0, 32'd1);
    check("t3_bank", {16'd0, bank[6'h0B]}, 32'h5678);

    // 16 back-to-back frames with rx_rdy never dropped.
    w0 = wr_addr_q.size(); d0 = n_done; ov0 = n_overlap; ac0 = n_acc;
    for (int i = 0; i < 16; i++) begin
      ea[i] = 16'($urandom_range(0, 63));
      ed[i] = 16'($urandom);
      send_frame(ea[i], ed[i], 0);
    end
    rx_rdy = 1'b0;
    wait_idle();
    check("t4_wr_done_count", n_done - d0, 32'd16);
    check("t4_rx_ack_in_write", n_overlap - ov0, 32'd0);
    check("t4_bytes_accepted", n_acc - ac0, 32'd64);
    check("t4_write_count", wr_addr_q.size() - w0, 32'd16);
    for (int i = 0; i < 16 && (w0 + i) < wr_addr_q.size(); i++) begin
      check("t4_write_addr", {16'd0, wr_addr_q[w0 + i]}, {16'd0, ea[i]});
      check("t4_write_data", {16'd0, wr_data_q[w0 + i]}, {16'd0, ed[i]});
    end

    // Random frames with random gaps against the frame-level model.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 63))
                                      : 16'($urandom_range(64, 65535));
      d = 16'($urandom);
      w0 = wr_addr_q.size(); d0 = n_done; nk0 = n_nack;
      send_frame(a, d, 3);
      rx_rdy = 1'b0;
      wait_idle();
      if (has_reg(a)) begin
        check("rnd_done", n_done - d0, 32'd1);
        check("rnd_si_rdy_len", last_run, 32'd1);
        check("rnd_bank", {16'd0, bank[a[5:0]]}, {16'd0, d});
      end else begin
        if (exp_err < 255) exp_err++;
        check("rnd_nack", n_nack - nk0, 32'd1);
        check("rnd_si_rdy_len", last_run, 32'd8);
        check("rnd_no_write", wr_addr_q.size() - w0, 32'd0);
      end
      check("rnd_err_count", {24'd0, err_count}, exp_err);
    end

    // Reset while a write is pending, then while mid-frame.
    send_frame(16'h00FF, 16'h1111, 0);
    rx_rdy = 1'b0;
    repeat (3) cycle();
    check("t5_si_rdy_pending", {31'd0, si_rdy}, 32'd1);
    rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'h00;
    #1;
    check("t5_rx_ack_in_rst", {31'd0, rx_ack}, 32'd0);
    cycle();
    rst = 1'b0; rx_rdy = 1'b0;
    check("t5_si_rdy", {31'd0, si_rdy}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_err_count", {24'd0, err_count}, 32'd0);
    exp_err = 0;
    send_byte(8'h00); send_byte(8'h0A);
    rx_rdy = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t5_busy_midframe", {31'd0, busy}, 32'd0);
    w0 = wr_addr_q.size();
    send_frame(16'h000B, 16'h9ABC, 0);
    rx_rdy = 1'b0;
    wait_idle();
    check("t5_write_count", wr_addr_q.size() - w0, 32'd1);
    check("t5_bank", {16'd0, bank[6'h0B]}, 32'h9ABC);

    // 300 nacks: error counter saturates at 255.
    for (int i = 0; i < 300; i++) begin
      send_frame(16'h1234, 16'($urandom), 0);
      rx_rdy = 1'b0;
      wait_idle();
      if (exp_err < 255) exp_err++;
      if (i == 253 || i == 254 || i == 255)
        check("t6_err_count_edge", {24'd0, err_count}, exp_err);
    end
    check("t6_err_count_sat", {24'd0, err_count}, 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
